// File: rtl/lith_subsys_model.sv
// Behavioural model of one lithography subsystem: one-hot commands with per-command
// latency, warm-up gating, abort, fault injection, error latching and an operation counter.
module lith_subsys_model #(
    parameter int                    N_CMD      = 3,
    parameter int                    TW         = 8,
    parameter logic [N_CMD*TW-1:0]   LAT        = {8'd6, 8'd6, 8'd6},
    parameter int                    WARMUP     = 10,
    parameter bit                    PULSE_DONE = 1'b0,
    localparam int                   CW         = (N_CMD > 1) ? $clog2(N_CMD) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CMD-1:0] cmd,
    input  logic             fault_inj,
    input  logic             err_clr,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CW-1:0]    active_idx,
    output logic [15:0]      op_count
);

    // WARMUP of 0 or 1 both mean ready on the first edge after reset.
    localparam int WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
    localparam int WW        = $clog2(WARM_LAST + 2);

    typedef enum logic [2:0] {
        S_WARMUP,
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_reg;
    logic [WW-1:0]   warm_cnt_reg;
    logic [TW-1:0]   timer_reg;

    // Terminal timer value per command; a latency of 0 behaves like 1.
    logic [TW-1:0]   lat_last [N_CMD];

    for (genvar gi = 0; gi < N_CMD; gi++) begin : g_lat
        localparam logic [TW-1:0] RAW = LAT[gi*TW +: TW];
        assign lat_last[gi] = (RAW == '0) ? '0 : RAW - TW'(1);
    end

    logic [CW-1:0]    cmd_idx;
    logic             cmd_multi;
    logic [N_CMD-1:0] sel_mask;
    logic             other_cmd;

    always_comb begin
        cmd_idx = '0;
        for (int i = 0; i < N_CMD; i++) begin
            if (cmd[i]) begin
                cmd_idx = CW'(i);
            end
        end
    end

    assign cmd_multi = (cmd & (cmd - N_CMD'(1))) != '0;
    assign sel_mask  = N_CMD'(1) << active_idx;
    assign other_cmd = (cmd & ~sel_mask) != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_WARMUP;
            warm_cnt_reg <= '0;
            timer_reg    <= '0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            active_idx   <= '0;
            op_count     <= 16'd0;
        end else begin
            case (state_reg)
                S_WARMUP: begin
                    if (warm_cnt_reg == WW'(WARM_LAST)) begin
                        ready     <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        warm_cnt_reg <= warm_cnt_reg + WW'(1);
                    end
                end
                S_IDLE: begin
                    if (cmd_multi) begin
                        err       <= 1'b1;
                        err_code  <= 2'b01;
                        state_reg <= S_ERROR;
                    end else if (cmd != '0) begin
                        active_idx <= cmd_idx;
                        timer_reg  <= '0;
                        busy       <= 1'b1;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (other_cmd) begin
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= 2'b01;
                        state_reg <= S_ERROR;
                    end else if (fault_inj) begin
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= 2'b10;
                        state_reg <= S_ERROR;
                    end else if (!cmd[active_idx]) begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (timer_reg == lat_last[active_idx]) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        op_count  <= op_count + 16'd1;
                        state_reg <= S_DONE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                S_DONE: begin
                    if (!cmd[active_idx]) begin
                        done      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (PULSE_DONE) begin
                        done <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (err_clr && (cmd == '0)) begin
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_WARMUP;
            endcase
        end
    end

endmodule

// File: doc/lith_subsys_model.md
# lith_subsys_model

Parametrised behavioural model of one lithography subsystem (loader, stage, source or similar) for the scanner sequencer testbench. It generalises the fixed-latency loader and stage models into one block with N commands, a per-command latency, warm-up gating, abort, fault injection, error reporting and an operation counter. One instance is placed per subsystem beneath the scanner top-level sequencer.

## Interface
- N_CMD, 3, number of one-hot command inputs (1..8)
- TW, 8, latency/timer width in bits
- LAT, {8'd6,8'd6,8'd6}, packed N_CMD×TW latencies; field i (bits i*TW +: TW) belongs to cmd[i]; a value of 0 is treated as 1
- WARMUP, 10, cycles from reset release to ready (0 = ready on first edge)
- PULSE_DONE, 0, 0 = done is a level held until the command drops; 1 = done is a one-cycle pulse
- clk  in  1  clock, all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- cmd  in  N_CMD  command request, one-hot expected, level-held by the sequencer
- fault_inj  in  1  testbench fault injection, sampled only in RUN
- err_clr  in  1  clears ERROR, honoured only when cmd==0
- ready  out  1  warm-up complete
- busy  out  1  command executing
- done  out  1  command complete
- err  out  1  error latched
- err_code  out  2  01 = multiple commands, 10 = injected fault, 00 = none
- active_idx  out  CW  index of the latched command, CW = max(1, clog2(N_CMD))
- op_count  out  16  number of completed operations, wraps from 0xFFFF to 0

## Operation
- States: WARMUP, IDLE, RUN, DONE, ERROR. Reset forces WARMUP, clears the timer, and drives every output to 0.
- WARMUP: the timer counts edges. ready=1 and the state moves to IDLE on edge WARMUP. cmd is ignored in this state. ready stays 1 until the next reset.
- IDLE: cmd==0 holds the state.
  - Exactly one bit set: latch its index into active_idx, clear the timer, set busy=1, go to RUN.
  - More than one bit set: err=1, err_code=01, go to ERROR.
- RUN: evaluated each edge, highest priority first.
  - (a) Any cmd bit other than cmd[active_idx] is set: ERROR, code 01.
  - (b) fault_inj=1: ERROR, code 10.
  - (c) cmd[active_idx]=0: abort. busy=0, return to IDLE, no done, op_count unchanged.
  - (d) Timer reaches LAT[active_idx]−1: done=1, busy=0, op_count+1, go to DONE.
  - (e) Otherwise increment the timer.
- DONE:
  - PULSE_DONE=0: done holds at 1 while cmd[active_idx]=1.
  - PULSE_DONE=1: done drops after one cycle.
  - cmd[active_idx]=0 exits to IDLE with done=0.
  - Other cmd bits are ignored until the exit.
- ERROR: busy=0 and done=0. err and err_code hold. err_clr with cmd==0 clears err and err_code and moves to IDLE. err_clr with cmd≠0 is ignored.
- active_idx holds its last value outside RUN and DONE.
- op_count is never cleared except by reset.

## Timing
- All outputs are registered.
- Latency: cmd sampled at edge E0 gives busy=1 after E0 and done=1 after edge E0+L, where L=max(LAT[i],1). busy is high for L cycles.
- Minimum command turnaround: the done→IDLE exit takes one edge. A new command is accepted on the following edge.
- Abort is seen one edge after cmd drops. busy falls at that edge.
- fault_inj arriving on the completion edge takes priority: ERROR, no done, no count.
- Reset asserted mid-operation clears the block immediately (asynchronous) and restarts WARMUP.

## Test plan
- Reset release, WARMUP=10, cmd=0 → ready rises after edge 10. busy, done and err stay 0 throughout.
- N_CMD=3, LAT={8'd4,8'd2,8'd6}, cmd=3'b010 held from IDLE → busy high for 2 cycles, then done=1 held until cmd=0. op_count=1, active_idx=1.
- cmd=3'b001 (L=6), cmd dropped after 3 cycles of busy → busy=0, done never asserted, op_count unchanged, next cmd accepted normally.
- cmd=3'b011 in IDLE → err=1, err_code=01. err_clr with cmd≠0 has no effect. err_clr with cmd=0 → err=0, IDLE.
- fault_inj pulsed on the completion edge of cmd[2] → err_code=10, done=0, op_count unchanged.
- PULSE_DONE=1, 65536 back-to-back operations → one-cycle done per operation, op_count wraps to 0. Reset asserted mid-RUN → all outputs 0 immediately, ready returns after WARMUP.
